seq_div32: RTL
==============

SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 SHALL have no parameters; operand and result width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement division, 0 = unsigned; latched with start.
REQ-006 a  input  32  dividend; latched with start.
REQ-007 b  input  32  divisor; latched with start.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  single-cycle pulse; results valid.
REQ-010 quotient  output  32  result quotient, held until next accepted start.
REQ-011 remainder  output  32  result remainder, held until next accepted start.
REQ-012 div_by_zero  output  1  latched flag for the last result; 1 if b was zero.

Function
REQ-013 SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE, radix-2 restoring algorithm, one quotient bit per CALC cycle.
REQ-014 IDLE: on start=1 at edge N, latch operand magnitudes (|a|, |b| when is_signed, raw otherwise), result signs and zero-divisor flag; clear 6-bit iteration counter; enter CALC; busy=1 from N+1.
REQ-015 CALC: each edge shift {rem,dividend} left 1, trial-subtract divisor from 33-bit partial remainder, keep the result and set quotient LSB when non-negative, restore otherwise; exactly 32 iterations, then FIX.
REQ-016 FIX: negate quotient if is_signed and sign(a)!=sign(b); negate remainder if is_signed and a negative (truncation toward zero, remainder takes dividend sign); register outputs; enter DONE.
REQ-017 DONE: done=1, busy=0 for exactly one cycle; next edge returns to IDLE.
REQ-018 Fixed latency: start sampled at edge N -> done high in the cycle following edge N+33; identical for every operand value, including divide-by-zero.
REQ-019 start while busy or in DONE SHALL be ignored; no queuing.
REQ-020 Changes on a, b, is_signed after the start edge SHALL NOT affect the running operation.
REQ-021 Divide by zero: quotient=0xFFFFFFFF, remainder=a (original, unnegated), div_by_zero=1, for both signed and unsigned.
REQ-022 Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-023 quotient, remainder, div_by_zero SHALL change only on the FIX edge; stable at all other times.
REQ-024 Negation SHALL be 32-bit two's complement (~x+1) with wrap; |0x80000000| treated as unsigned 2^31.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-026 Reset mid-operation SHALL abandon the division with no done pulse; first start after rst_n release behaves as from power-up.
REQ-027 rst_n release SHALL take effect at the next rising clk edge; start sampled on that edge is accepted.

Verification
REQ-028 Unsigned: a=100, b=7, is_signed=0, start at edge N -> done in cycle after N+33, quotient=14, remainder=2, div_by_zero=0; busy high exactly 33 cycles.
REQ-029 Signed: a=0xFFFFFFF9 (-7), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); a=7, b=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
REQ-030 Divide by zero: a=5, b=0, both modes -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, latency unchanged.
REQ-031 Corners: signed 0x80000000/0xFFFFFFFF -> 0x80000000 rem 0; unsigned 0xFFFFFFFF/1 -> 0xFFFFFFFF rem 0; unsigned 3/0xFFFFFFFF -> 0 rem 3.
REQ-032 Protocol: second start and changed a/b during busy -> ignored, first result unchanged; rst_n low at cycle 10 of CALC -> busy=0, no done, outputs 0; new start then completes normally.
REQ-033 Random: 10k back-to-back signed/unsigned pairs checked against a reference model, including b=0 and ±2^31 operands.

Source files
------------

// File: rtl/seq_div32.sv
// Sequential 32-bit signed/unsigned divider: radix-2 restoring, one quotient bit per clock,
// with a fixed latency from the accepted start to the done pulse.
module seq_div32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        div_by_zero_q, div_by_zero_d;

  logic [32:0] shifted;
  logic [31:0] sub;
  logic        fits;
  logic [31:0] abs_a, abs_b;

  always_comb begin
    state_d       = state_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dbz_d         = dbz_q;
    busy_d        = busy_q;
    done_d        = done_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    abs_a   = (is_signed && a[31]) ? (~a + 32'd1) : a;
    abs_b   = (is_signed && b[31]) ? (~b + 32'd1) : b;
    // A successful trial subtract always leaves a value below the divisor, so 32 bits suffice.
    shifted = {rem_q, dvd_q[31]};
    fits    = (shifted >= {1'b0, dvs_q});
    sub     = shifted[31:0] - dvs_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          dvd_d     = abs_a;
          dvs_d     = abs_b;
          rem_d     = 32'd0;
          cnt_d     = 6'd0;
          neg_quo_d = is_signed && (a[31] ^ b[31]);
          neg_rem_d = is_signed && a[31];
          dbz_d     = (b == 32'd0);
          busy_d    = 1'b1;
        end
      end
      CALC: begin
        rem_d = fits ? sub : shifted[31:0];
        dvd_d = {dvd_q[30:0], fits};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        // With a zero divisor the remainder path yields |a|, which re-signs back to the raw a.
        quotient_d    = dbz_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~dvd_q + 32'd1) : dvd_q);
        remainder_d   = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        div_by_zero_d = dbz_q;
        busy_d        = 1'b0;
        done_d        = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dvd_q         <= 32'd0;
      dvs_q         <= 32'd0;
      rem_q         <= 32'd0;
      cnt_q         <= 6'd0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= 32'd0;
      remainder_q   <= 32'd0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dbz_q         <= dbz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule
